// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/memory/write-back
// and drives the datapath strobes as a Moore function of the current state.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_uncond_br,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        BRANCH   = 4'd8,
        ALU_WB   = 4'd9
    } state_t;

    localparam logic [3:0] OP_ANDI = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_CBZ  = 4'd8;
    localparam logic [3:0] OP_B    = 4'd9;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op_q;
    logic       alu_src_q;

    // The branch condition is applied by the datapath when it gates pc_write_cond.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU controls captured in EXEC so ALU_WB can replay them without decoding again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b0;
        end else if (state_q == EXEC_R || state_q == EXEC_I) begin
            alu_op_q  <= alu_op;
            alu_src_q <= alu_src;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode <= 4'd3)        state_d = EXEC_R;
                else if (opcode <= 4'd5)   state_d = EXEC_I;
                else if (opcode <= 4'd7)   state_d = MEM_ADDR;
                else if (opcode <= OP_B)   state_d = BRANCH;
                else                       state_d = FETCH;
            end
            EXEC_R:   state_d = ALU_WB;
            EXEC_I:   state_d = ALU_WB;
            MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
            WB_MEM:   state_d = FETCH;
            BRANCH:   state_d = FETCH;
            ALU_WB:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_uncond_br  = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        // Reset masks outputs combinationally so mem_req drops before any clock edge.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                DECODE:   illegal = (opcode >= 4'd10);
                EXEC_R:   alu_op  = opcode[1:0];
                EXEC_I: begin
                    alu_src = 1'b1;
                    alu_op  = (opcode == OP_ANDI) ? 2'b10 : 2'b00;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    alu_src   = alu_src_q;
                    alu_op    = alu_op_q;
                end
                MEM_ADDR: alu_src = 1'b1;
                MEM_RD:   mem_req = 1'b1;
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 1'b1;
                end
                BRANCH: begin
                    if (opcode == OP_CBZ) begin
                        pc_write_cond = 1'b1;
                        alu_op        = 2'b01;
                    end else begin
                        pc_uncond_br  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle trace checks for multicycle_control, plus an async reset
// sequence during a stalled store.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_write, pc_write, pc_write_cond, pc_uncond_br;
    logic       reg_write, wb_sel, alu_src, illegal;
    logic [1:0] alu_op;
    logic [3:0] state;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_uncond_br(pc_uncond_br), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src(alu_src), .alu_op(alu_op), .state(state), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Output bundle: {mem_req, mem_we, ir_write, pc_write, pc_write_cond,
    //                 pc_uncond_br, reg_write, wb_sel, alu_src, alu_op[1:0], illegal}
    localparam logic [11:0] O_NONE  = 12'b0000_0000_0000;
    localparam logic [11:0] O_FETCH = 12'b1011_0000_0000;
    localparam logic [11:0] O_FWAIT = 12'b1000_0000_0000;
    localparam logic [11:0] O_R1    = 12'b0000_0000_0010;
    localparam logic [11:0] O_R2    = 12'b0000_0000_0100;
    localparam logic [11:0] O_R3    = 12'b0000_0000_0110;
    localparam logic [11:0] O_WB0   = 12'b0000_0010_0000;
    localparam logic [11:0] O_WB1   = 12'b0000_0010_0010;
    localparam logic [11:0] O_WB2   = 12'b0000_0010_0100;
    localparam logic [11:0] O_WB3   = 12'b0000_0010_0110;
    localparam logic [11:0] O_ADDI  = 12'b0000_0000_1000;
    localparam logic [11:0] O_ANDI  = 12'b0000_0000_1100;
    localparam logic [11:0] O_WBAI  = 12'b0000_0010_1000;
    localparam logic [11:0] O_WBNI  = 12'b0000_0010_1100;
    localparam logic [11:0] O_MADDR = 12'b0000_0000_1000;
    localparam logic [11:0] O_MRD   = 12'b1000_0000_0000;
    localparam logic [11:0] O_MWR   = 12'b1100_0000_0000;
    localparam logic [11:0] O_WBMEM = 12'b0000_0011_0000;
    localparam logic [11:0] O_CBZ   = 12'b0000_1000_0010;
    localparam logic [11:0] O_B     = 12'b0000_0100_0000;
    localparam logic [11:0] O_ILL   = 12'b0000_0000_0001;

    typedef struct {
        logic [3:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [11:0] outs;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [11:0] outs_now();
        return {mem_req, mem_we, ir_write, pc_write, pc_write_cond, pc_uncond_br,
                reg_write, wb_sel, alu_src, alu_op, illegal};
    endfunction

    task automatic check(input string name, input logic [3:0] exp_st, input logic [11:0] exp_outs);
        n_vec++;
        if (state !== exp_st || outs_now() !== exp_outs) begin
            n_bad++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, outs_now(), exp_st, exp_outs);
        end
    endtask

    task automatic apply(input string name, input logic [3:0] op, input logic mr,
                         input logic [3:0] exp_st, input logic [11:0] exp_outs);
        @(negedge clock);
        opcode    = op;
        mem_ready = mr;
        alu_zero  = ~alu_zero;
        #1;
        check(name, exp_st, exp_outs);
    endtask

    task automatic add_vec(input logic [3:0] op, input logic mr, input logic [3:0] st,
                           input logic [11:0] outs);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.outs = outs;
        tbl.push_back(v);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 4'd0;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;

        // First edge after release must still be a stalled fetch.
        add_vec(0, 0, 0, O_FWAIT);
        add_vec(0, 1, 0, O_FETCH); add_vec(0, 1, 1, O_NONE); add_vec(0, 1, 2, O_NONE); add_vec(0, 1, 9, O_WB0);
        add_vec(1, 1, 0, O_FETCH); add_vec(1, 1, 1, O_NONE); add_vec(1, 1, 2, O_R1);   add_vec(1, 1, 9, O_WB1);
        add_vec(2, 1, 0, O_FETCH); add_vec(2, 1, 1, O_NONE); add_vec(2, 1, 2, O_R2);   add_vec(2, 1, 9, O_WB2);
        add_vec(3, 1, 0, O_FETCH); add_vec(3, 1, 1, O_NONE); add_vec(3, 1, 2, O_R3);   add_vec(3, 1, 9, O_WB3);
        add_vec(4, 1, 0, O_FETCH); add_vec(4, 1, 1, O_NONE); add_vec(4, 1, 3, O_ADDI); add_vec(4, 1, 9, O_WBAI);
        add_vec(5, 1, 0, O_FETCH); add_vec(5, 1, 1, O_NONE); add_vec(5, 1, 3, O_ANDI); add_vec(5, 1, 9, O_WBNI);
        add_vec(6, 1, 0, O_FETCH); add_vec(6, 1, 1, O_NONE); add_vec(6, 0, 4, O_MADDR);
        add_vec(6, 0, 5, O_MRD);   add_vec(6, 0, 5, O_MRD);  add_vec(6, 1, 5, O_MRD);  add_vec(6, 1, 7, O_WBMEM);
        add_vec(7, 1, 0, O_FETCH); add_vec(7, 1, 1, O_NONE); add_vec(7, 1, 4, O_MADDR); add_vec(7, 1, 6, O_MWR);
        add_vec(8, 1, 0, O_FETCH); add_vec(8, 1, 1, O_NONE); add_vec(8, 1, 8, O_CBZ);
        add_vec(9, 1, 0, O_FETCH); add_vec(9, 1, 1, O_NONE); add_vec(9, 1, 8, O_B);
        add_vec(12, 1, 0, O_FETCH); add_vec(12, 1, 1, O_ILL); add_vec(12, 0, 0, O_FWAIT);
        add_vec(15, 1, 0, O_FETCH); add_vec(15, 1, 1, O_ILL); add_vec(15, 0, 0, O_FWAIT);
        add_vec(10, 0, 0, O_FWAIT); add_vec(10, 1, 0, O_FETCH); add_vec(10, 1, 1, O_ILL);

        // Reset held across edges with mem_ready high: nothing may be requested.
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", 4'd0, O_NONE);
        @(negedge clock);
        reset     = 1'b0;
        mem_ready = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].outs);
        end

        // Store stalled in MEM_WR, then async reset between edges.
        apply("st_fetch", 7, 1, 0, O_FETCH);
        apply("st_decode", 7, 0, 1, O_NONE);
        apply("st_addr", 7, 0, 4, O_MADDR);
        apply("st_wait0", 7, 0, 6, O_MWR);
        apply("st_wait1", 7, 0, 6, O_MWR);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 4'd0, O_NONE);
        @(posedge clock);
        #1;
        check("reset_edge", 4'd0, O_NONE);
        @(negedge clock);
        reset = 1'b0;
        apply("rel_fwait", 0, 0, 0, O_FWAIT);
        apply("rel_fetch", 0, 1, 0, O_FETCH);
        apply("rel_decode", 0, 1, 1, O_NONE);
        apply("rel_exec", 0, 1, 2, O_NONE);
        apply("rel_wb", 0, 1, 9, O_WB0);
        apply("rel_next", 0, 0, 0, O_FWAIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clock  in  1  single system clock; all state updates on the rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clock.
REQ-003 opcode  in  4  instruction opcode, taken from the instruction register (IR[15:12]).
REQ-004 alu_zero  in  1  ALU zero flag; used in the branch state.
REQ-005 mem_ready  in  1  memory handshake; completes the current fetch, load or store access.
REQ-006 mem_req  out  1  memory access request.
REQ-007 mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1.
REQ-008 ir_write  out  1  loads IR from memory read data.
REQ-009 pc_write  out  1  unconditional PC update: PC <= pc_next (pc+2).
REQ-010 pc_write_cond  out  1  conditional PC update; the datapath gates it with alu_zero (PC <= pc + (signext<<1)).
REQ-011 pc_uncond_br  out  1  unconditional branch update: PC <= pc + (signext<<1).
REQ-012 reg_write  out  1  register file write enable.
REQ-013 wb_sel  out  1  write-back source: 0 = ALU, 1 = memory data.
REQ-014 alu_src  out  1  ALU B source: 0 = register, 1 = sign-extended immediate.
REQ-015 alu_op  out  2  ALU function: 00 = add, 01 = sub, 10 = and, 11 = or.
REQ-016 state  out  4  current state encoding, for debug.
REQ-017 illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

Function
REQ-018 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI, 5 ANDI (I-type); 6 LD; 7 ST; 8 CBZ; 9 B; 10-15 are illegal.
REQ-019 State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, BRANCH=8, ALU_WB=9; encodings 10-15 are unreachable and go to FETCH on the next edge.
REQ-020 Outputs are a Moore function of state. Exceptions: ir_write, pc_write and illegal also depend on mem_ready or opcode, as stated below. All outputs not listed for a state are 0.
REQ-021 FETCH: mem_req=1, mem_we=0, stay in FETCH while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
REQ-022 DECODE: all strobes 0. Next state: EXEC_R for opcode 0-3, EXEC_I for 4-5, MEM_ADDR for 6-7, BRANCH for 8-9. Opcode 10-15: illegal=1 for this cycle, next state FETCH.
REQ-023 EXEC_R: alu_src=0, alu_op=opcode[1:0]; next state ALU_WB.
REQ-024 EXEC_I: alu_src=1, alu_op=00 for ADDI and 10 for ANDI; next state ALU_WB.
REQ-025 ALU_WB: reg_write=1, wb_sel=0, alu_op and alu_src held from the previous EXEC state; next state FETCH.
REQ-026 MEM_ADDR: alu_src=1, alu_op=00; next state MEM_RD for LD, MEM_WR for ST.
REQ-027 MEM_RD: mem_req=1, mem_we=0; hold while mem_ready=0; go to WB_MEM on mem_ready=1.
REQ-028 MEM_WR: mem_req=1, mem_we=1; hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-029 WB_MEM: reg_write=1, wb_sel=1; next state FETCH.
REQ-030 BRANCH, CBZ: alu_op=01, alu_src=0, pc_write_cond=1. BRANCH, B: pc_uncond_br=1. Next state FETCH in both cases.
REQ-031 Per-type latency with mem_ready=1: R/I = 4 cycles, LD = 5, ST = 4, CBZ/B = 3, illegal = 2. Each wait cycle adds 1.
REQ-032 mem_req shall stay high continuously until the handshake completes; mem_req and mem_we shall not change while waiting.
REQ-033 At most one of pc_write, pc_write_cond and pc_uncond_br shall be asserted in any cycle.
REQ-034 opcode is sampled only in DECODE, MEM_ADDR, EXEC and BRANCH; it is held stable by IR, which changes only on ir_write.

Reset
REQ-035 While reset=1: state=FETCH and all outputs 0, including mem_req. The reset is asynchronous, so it applies mid-wait or mid-instruction.
REQ-036 On the first rising edge after reset deasserts, the block shall sit in FETCH with mem_req=1. No partial instruction effects (reg_write, PC writes) are emitted after reset.

Verification
REQ-037 Reset, then ADD (opcode 0) with mem_ready=1: states 0,1,2,9,0. reg_write=1 only in state 9, alu_op=00 in states 2 and 9.
REQ-038 LD (opcode 6) with mem_ready=0 for 2 cycles in MEM_RD: states 0,1,4,5,5,5,7,0. mem_req stays 1 and mem_we stays 0 for the three MEM_RD cycles. wb_sel=1 and reg_write=1 in state 7.
REQ-039 CBZ (opcode 8): pc_write_cond=1 and alu_op=01 in BRANCH for one cycle. B (opcode 9): pc_uncond_br=1 for one cycle. Neither asserts pc_write.
REQ-040 Opcode 12: illegal=1 pulse in DECODE, next state FETCH, no reg_write or PC write besides the fetch.
REQ-041 Assert reset asynchronously mid-MEM_WR wait: mem_req falls to 0 before the next clock edge, state=0. After release the FETCH handshake resumes normally.
REQ-042 ST (opcode 7) with mem_ready=1: states 0,1,4,6,0. mem_we=1 only in state 6, reg_write never asserted.
